// File: rtl/cr_iu_gated_clk_regbank_if.sv
// Write, clear and dual read-port bundle for cr_iu_gated_clk_regbank.
// The requester drives the master side and the register bank is the slave.
interface cr_iu_gated_clk_regbank_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = WIDTH / 8;

    logic             x_write_en;
    logic [AW-1:0]    x_write_idx;
    logic [BW-1:0]    x_write_be;
    logic [WIDTH-1:0] write_data;
    logic             x_clr_all;
    logic [AW-1:0]    x_rd_idx0;
    logic [AW-1:0]    x_rd_idx1;
    logic [WIDTH-1:0] x_rd_data0;
    logic [WIDTH-1:0] x_rd_data1;
    logic             x_rd_vld0;
    logic             x_rd_vld1;
    logic [DEPTH-1:0] x_vld_vec;

    modport master (
        output x_write_en, x_write_idx, x_write_be, write_data, x_clr_all,
        output x_rd_idx0, x_rd_idx1,
        input  x_rd_data0, x_rd_data1, x_rd_vld0, x_rd_vld1, x_vld_vec
    );

    modport slave (
        input  x_write_en, x_write_idx, x_write_be, write_data, x_clr_all,
        input  x_rd_idx0, x_rd_idx1,
        output x_rd_data0, x_rd_data1, x_rd_vld0, x_rd_vld1, x_vld_vec
    );
endinterface

// File: rtl/cr_iu_gated_clk_regbank.sv
// Small register bank where every entry runs on its own gated clock, with
// byte-enable writes, a global clear and two combinational read ports.

module gated_clk_cell (
    input  logic clk_in,
    input  logic global_en,
    input  logic module_en,
    input  logic local_en,
    input  logic external_en,
    input  logic pad_yy_gate_clk_en_b,
    input  logic pad_yy_test_mode,
    output logic clk_out
);
    logic clk_en_bf_latch;
    logic clk_en_af_latch;

    assign clk_en_bf_latch = (global_en & module_en & local_en) | external_en
                           | ~pad_yy_gate_clk_en_b | pad_yy_test_mode;

    // Enable is captured while the clock is low so the gated clock never glitches.
    always_latch begin
        if (!clk_in) begin
            clk_en_af_latch <= clk_en_bf_latch;
        end
    end

    assign clk_out = clk_in & clk_en_af_latch;
endmodule

module cr_iu_gated_clk_regbank #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 4,
    parameter int BYPASS = 0
) (
    input  logic forever_cpuclk,
    input  logic cpurst_b,
    input  logic cp0_yy_clk_en,
    input  logic pad_yy_gate_clk_en_b,
    input  logic pad_yy_test_mode,
    input  logic x_randclk_reg_mod_en_w32,
    cr_iu_gated_clk_regbank_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = WIDTH / 8;

    logic [WIDTH-1:0] entry_data [DEPTH];
    logic [DEPTH-1:0] valid_vec;
    logic [DEPTH-1:0] wr_hit;
    logic [DEPTH-1:0] entry_clk;
    logic             wr_be_any;
    logic             fwd_en;

    assign wr_be_any = |bus.x_write_be;

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic [WIDTH-1:0] data_q;
        logic             vld_q;

        assign wr_hit[i] = bus.x_write_en && (bus.x_write_idx == AW'(i)) && wr_be_any;

        gated_clk_cell u_gate (
            .clk_in               (forever_cpuclk),
            .global_en            (cp0_yy_clk_en),
            .module_en            (x_randclk_reg_mod_en_w32),
            .local_en             (wr_hit[i] | bus.x_clr_all | ~cpurst_b),
            .external_en          (1'b0),
            .pad_yy_gate_clk_en_b (pad_yy_gate_clk_en_b),
            .pad_yy_test_mode     (pad_yy_test_mode),
            .clk_out              (entry_clk[i])
        );

        // The gate may also be forced open by test pins, so the update is qualified again here.
        always_ff @(posedge entry_clk[i]) begin
            if (!cpurst_b || bus.x_clr_all) begin
                data_q <= '0;
                vld_q  <= 1'b0;
            end else if (wr_hit[i]) begin
                for (int b = 0; b < BW; b++) begin
                    if (bus.x_write_be[b]) begin
                        data_q[8*b +: 8] <= bus.write_data[8*b +: 8];
                    end
                end
                vld_q <= 1'b1;
            end
        end

        assign entry_data[i] = data_q;
        assign valid_vec[i]  = vld_q;
    end

    assign bus.x_vld_vec = valid_vec;
    assign fwd_en = (BYPASS != 0) && bus.x_write_en && !bus.x_clr_all;

    logic [AW-1:0]    rd_idx  [2];
    logic [WIDTH-1:0] rd_data [2];
    logic             rd_vld  [2];
    logic             rd_hit  [2];

    assign rd_idx[0] = bus.x_rd_idx0;
    assign rd_idx[1] = bus.x_rd_idx1;

    // Indices past the last entry match nothing and therefore read as zero, even when forwarding.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = '0;
            rd_vld[p]  = 1'b0;
            rd_hit[p]  = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_idx[p] == AW'(i)) begin
                    rd_data[p] = entry_data[i];
                    rd_vld[p]  = valid_vec[i];
                    rd_hit[p]  = 1'b1;
                end
            end
            if (fwd_en && rd_hit[p] && (rd_idx[p] == bus.x_write_idx)) begin
                for (int b = 0; b < BW; b++) begin
                    if (bus.x_write_be[b]) begin
                        rd_data[p][8*b +: 8] = bus.write_data[8*b +: 8];
                    end
                end
                rd_vld[p] = rd_vld[p] | wr_be_any;
            end
        end
    end

    assign bus.x_rd_data0 = rd_data[0];
    assign bus.x_rd_data1 = rd_data[1];
    assign bus.x_rd_vld0  = rd_vld[0];
    assign bus.x_rd_vld1  = rd_vld[1];
endmodule

// File: tb/tb_cr_iu_gated_clk_regbank.sv
// Scoreboard bench for two bank configurations: 4 entries without forwarding
// and 3 entries with forwarding, both driven by the same stimulus.
module tb_cr_iu_gated_clk_regbank;
    typedef struct packed {
        logic [31:0] data0;
        logic        vld0;
        logic [31:0] data1;
        logic        vld1;
        logic [3:0]  vec;
    } exp_t;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    logic gce = 1'b1;
    logic mod_en = 1'b1;
    logic gate_b = 1'b1;
    logic test_mode = 1'b0;

    logic g_gce = 1'b1;
    logic g_mod = 1'b1;
    logic g_gate_b = 1'b1;
    logic g_tm = 1'b0;

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;

    exp_t q_a[$];
    exp_t q_b[$];

    logic [31:0] m_data [2][4];
    logic        m_vld  [2][4];
    int          m_depth [2] = '{4, 3};
    bit          m_byp   [2] = '{1'b0, 1'b1};

    logic        c_rst_b;
    logic        c_we;
    logic [1:0]  c_widx;
    logic [3:0]  c_be;
    logic [31:0] c_wd;
    logic        c_clr;

    always #5 clk = ~clk;

    cr_iu_gated_clk_regbank_if #(.WIDTH(32), .DEPTH(4)) bus_a ();
    cr_iu_gated_clk_regbank_if #(.WIDTH(32), .DEPTH(3)) bus_b ();

    cr_iu_gated_clk_regbank #(.WIDTH(32), .DEPTH(4), .BYPASS(0)) dut_a (
        .forever_cpuclk           (clk),
        .cpurst_b                 (rst_b),
        .cp0_yy_clk_en            (gce),
        .pad_yy_gate_clk_en_b     (gate_b),
        .pad_yy_test_mode         (test_mode),
        .x_randclk_reg_mod_en_w32 (mod_en),
        .bus                      (bus_a.slave)
    );

    cr_iu_gated_clk_regbank #(.WIDTH(32), .DEPTH(3), .BYPASS(1)) dut_b (
        .forever_cpuclk           (clk),
        .cpurst_b                 (rst_b),
        .cp0_yy_clk_en            (gce),
        .pad_yy_gate_clk_en_b     (gate_b),
        .pad_yy_test_mode         (test_mode),
        .x_randclk_reg_mod_en_w32 (mod_en),
        .bus                      (bus_b.slave)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    function automatic void model_read(input int d, input logic [1:0] idx,
                                       output logic [31:0] data, output logic vld);
        data = '0;
        vld  = 1'b0;
        if (int'(idx) < m_depth[d]) begin
            data = m_data[d][idx];
            vld  = m_vld[d][idx];
            if (m_byp[d] && c_we && !c_clr && idx == c_widx) begin
                data = merge(data, c_wd, c_be);
                vld  = vld || (c_be != 4'b0);
            end
        end
    endfunction

    function automatic logic [3:0] model_vec(input int d);
        logic [3:0] v = '0;
        for (int i = 0; i < m_depth[d]; i++) v[i] = m_vld[d][i];
        return v;
    endfunction

    // Entry state moves only when the clock reaches it: both enables, or a test pin forcing it on.
    function automatic void model_edge();
        bit clk_runs;
        clk_runs = (gce && mod_en) || !gate_b || test_mode;
        if (!clk_runs) return;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < m_depth[d]; i++) begin
                if (!c_rst_b || c_clr) begin
                    m_data[d][i] = '0;
                    m_vld[d][i]  = 1'b0;
                end else if (c_we && c_be != 4'b0 && int'(c_widx) == i) begin
                    m_data[d][i] = merge(m_data[d][i], c_wd, c_be);
                    m_vld[d][i]  = 1'b1;
                end
            end
        end
    endfunction

    task automatic applyStimulus(input logic rb, input logic we, input logic [1:0] widx,
                                 input logic [3:0] be, input logic [31:0] wd, input logic clr,
                                 input logic [1:0] r0, input logic [1:0] r1);
        exp_t ea;
        exp_t eb;
        @(negedge clk);
        rst_b = rb;  gce = g_gce;  mod_en = g_mod;  gate_b = g_gate_b;  test_mode = g_tm;
        c_rst_b = rb;  c_we = we;  c_widx = widx;  c_be = be;  c_wd = wd;  c_clr = clr;
        bus_a.x_write_en = we;  bus_a.x_write_idx = widx;  bus_a.x_write_be = be;
        bus_a.write_data = wd;  bus_a.x_clr_all = clr;
        bus_a.x_rd_idx0 = r0;   bus_a.x_rd_idx1 = r1;
        bus_b.x_write_en = we;  bus_b.x_write_idx = widx;  bus_b.x_write_be = be;
        bus_b.write_data = wd;  bus_b.x_clr_all = clr;
        bus_b.x_rd_idx0 = r0;   bus_b.x_rd_idx1 = r1;
        if (checking) begin
            model_read(0, r0, ea.data0, ea.vld0);
            model_read(0, r1, ea.data1, ea.vld1);
            ea.vec = model_vec(0);
            model_read(1, r0, eb.data0, eb.vld0);
            model_read(1, r1, eb.data1, eb.vld1);
            eb.vec = model_vec(1);
            q_a.push_back(ea);
            q_b.push_back(eb);
        end
        model_edge();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: compares the outputs of each cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                checkOutput("a.rd_data0", bus_a.x_rd_data0, e.data0);
                checkOutput("a.rd_vld0", 32'(bus_a.x_rd_vld0), 32'(e.vld0));
                checkOutput("a.rd_data1", bus_a.x_rd_data1, e.data1);
                checkOutput("a.rd_vld1", 32'(bus_a.x_rd_vld1), 32'(e.vld1));
                checkOutput("a.vld_vec", 32'(bus_a.x_vld_vec), 32'(e.vec));
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                checkOutput("b.rd_data0", bus_b.x_rd_data0, e.data0);
                checkOutput("b.rd_vld0", 32'(bus_b.x_rd_vld0), 32'(e.vld0));
                checkOutput("b.rd_data1", bus_b.x_rd_data1, e.data1);
                checkOutput("b.rd_vld1", 32'(bus_b.x_rd_vld1), 32'(e.vld1));
                checkOutput("b.vld_vec", 32'({1'b0, bus_b.x_vld_vec}), 32'(e.vec));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                m_data[d][i] = '0;
                m_vld[d][i]  = 1'b0;
            end
        end
        bus_a.x_write_en = 1'b0;  bus_a.x_write_idx = '0;  bus_a.x_write_be = '0;
        bus_a.write_data = '0;    bus_a.x_clr_all = 1'b0;
        bus_a.x_rd_idx0 = '0;     bus_a.x_rd_idx1 = '0;
        bus_b.x_write_en = 1'b0;  bus_b.x_write_idx = '0;  bus_b.x_write_be = '0;
        bus_b.write_data = '0;    bus_b.x_clr_all = 1'b0;
        bus_b.x_rd_idx0 = '0;     bus_b.x_rd_idx1 = '0;

        applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 1'b0, 2'd0, 2'd1);
        checking = 1'b1;
        applyStimulus(1'b0, 1'b1, 2'd2, 4'hF, 32'hCAFEF00D, 1'b0, 2'd0, 2'd2);
        applyStimulus(1'b1, 1'b0, 2'd0, 4'h0, 32'h0, 1'b0, 2'd0, 2'd2);

        $display("[TB] single write then partial byte write");
        applyStimulus(1'b1, 1'b1, 2'd1, 4'hF, 32'hDEADBEEF, 1'b0, 2'd1, 2'd1);
        applyStimulus(1'b1, 1'b0, 2'd0, 4'h0, 32'h0, 1'b0, 2'd1, 2'd0);
        applyStimulus(1'b1, 1'b1, 2'd1, 4'b0101, 32'h11223344, 1'b0, 2'd1, 2'd1);
        applyStimulus(1'b1, 1'b0, 2'd0, 4'h0, 32'h0, 1'b0, 2'd1, 2'd1);

        $display("[TB] clear against simultaneous write");
        applyStimulus(1'b1, 1'b1, 2'd2, 4'hF, 32'h55667788, 1'b0, 2'd2, 2'd1);
        applyStimulus(1'b1, 1'b1, 2'd2, 4'hF, 32'h99AABBCC, 1'b1, 2'd2, 2'd1);
        applyStimulus(1'b1, 1'b0, 2'd0, 4'h0, 32'h0, 1'b0, 2'd2, 2'd1);

        $display("[TB] same-cycle forwarding");
        applyStimulus(1'b1, 1'b1, 2'd0, 4'b1000, 32'hAA000000, 1'b0, 2'd1, 2'd0);
        applyStimulus(1'b1, 1'b0, 2'd0, 4'h0, 32'h0, 1'b0, 2'd0, 2'd0);
        applyStimulus(1'b1, 1'b1, 2'd0, 4'b0000, 32'h12345678, 1'b0, 2'd0, 2'd0);

        $display("[TB] out-of-range index");
        applyStimulus(1'b1, 1'b1, 2'd3, 4'hF, 32'h0BADF00D, 1'b0, 2'd3, 2'd3);
        applyStimulus(1'b1, 1'b0, 2'd0, 4'h0, 32'h0, 1'b0, 2'd3, 2'd0);

        $display("[TB] clock gating and test-mode override");
        g_gce = 1'b0;
        applyStimulus(1'b1, 1'b1, 2'd0, 4'hF, 32'h13579BDF, 1'b0, 2'd0, 2'd1);
        applyStimulus(1'b1, 1'b0, 2'd0, 4'h0, 32'h0, 1'b0, 2'd0, 2'd1);
        g_tm = 1'b1;
        applyStimulus(1'b1, 1'b1, 2'd0, 4'hF, 32'h2468ACE0, 1'b0, 2'd0, 2'd1);
        applyStimulus(1'b1, 1'b0, 2'd0, 4'h0, 32'h0, 1'b0, 2'd0, 2'd1);
        g_tm = 1'b0;  g_gce = 1'b1;  g_mod = 1'b0;
        applyStimulus(1'b1, 1'b1, 2'd1, 4'hF, 32'h77777777, 1'b0, 2'd1, 2'd0);
        g_gate_b = 1'b0;
        applyStimulus(1'b1, 1'b1, 2'd1, 4'h3, 32'h88888888, 1'b0, 2'd1, 2'd0);
        g_gate_b = 1'b1;  g_mod = 1'b1;
        applyStimulus(1'b1, 1'b0, 2'd0, 4'h0, 32'h0, 1'b0, 2'd1, 2'd0);

        $display("[TB] reset together with a write");
        applyStimulus(1'b0, 1'b1, 2'd1, 4'hF, 32'hFFFFFFFF, 1'b0, 2'd1, 2'd0);
        applyStimulus(1'b1, 1'b0, 2'd0, 4'h0, 32'h0, 1'b0, 2'd1, 2'd0);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            g_gce    = ($urandom_range(0, 7) != 0);
            g_mod    = ($urandom_range(0, 7) != 0);
            g_gate_b = ($urandom_range(0, 15) != 0);
            g_tm     = ($urandom_range(0, 15) == 0);
            applyStimulus(($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom,
                          ($urandom_range(0, 24) == 0), 2'($urandom_range(0, 3)),
                          2'($urandom_range(0, 3)));
        end

        @(negedge clk);
        #4;
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d/%0d pending expected 0/0",
                     q_a.size(), q_b.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
